fft_out_serializer: RTL and testbench
=====================================

Name: fft_out_serializer

Overview:
Output stage directly downstream of the butterfly/demux/register path in the FFT datapath. It captures one complete FFT result vector of N complex words in parallel and emits it as a serial 34-bit stream on the chip output. It also undoes the butterfly's bit-reversed bin order. Two ping-pong banks let a new vector be accepted while the previous one drains, and the output side supports valid/ready backpressure.

Parameters:
N, 8, points per FFT vector (power of 2, at least 2)
LOGN, 3, log2(N)
DW, 34, complex word width: [33:17] real, [16:0] imag, two's complement
REORDER, 1, 1 = emit bins in natural order from bit-reversed lanes; 0 = emit lanes in lane order

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-high (asserted = 1)
in_valid  input  1  data_in holds a full result vector
in_ready  output  1  a bank is free; the vector is captured when in_valid && in_ready at the edge
data_in  input  N*DW  lane k = data_in[k*DW +: DW]; lane k carries bin bitrev(k)
out_valid  output  1  data_out holds a valid word
out_ready  input  1  downstream accepts the word this edge
data_out  output  DW  serial complex word
out_index  output  LOGN  bin number of data_out
out_last  output  1  high with the final word (out_index = N-1) of a vector

Behaviour:
- All outputs are registered. Reset values: in_ready=1, out_valid=0, data_out=0, out_index=0, out_last=0. Internal: both banks EMPTY, wr_ptr=0, rd_ptr=0, read counter=0.
- Reset acts immediately, with no clock edge needed. Any partially emitted vector and any buffered vectors are discarded.
- Each bank holds N words and has status EMPTY or FULL.
- Write side:
  - in_ready = registered (bank[wr_ptr] == EMPTY).
  - On an accept edge: copy all N lanes into bank[wr_ptr], mark it FULL, toggle wr_ptr.
  - in_valid while in_ready=0 is ignored; nothing is captured. Upstream holds its data until accepted.
- Read side:
  - The output register "loads" when bank[rd_ptr] is FULL and either out_valid=0 or out_ready=1.
  - On a load: data_out = bank[rd_ptr][lane], with lane = bitrev(cnt) if REORDER=1, else cnt. Also out_index=cnt, out_last=(cnt==N-1), out_valid=1, cnt=cnt+1.
  - When the word with cnt=N-1 is loaded: mark bank[rd_ptr] EMPTY, toggle rd_ptr, wrap cnt to 0.
  - If out_valid && out_ready and no load occurs: out_valid=0 and out_last=0. data_out and out_index hold their last values.
  - While out_valid && !out_ready: data_out, out_index and out_last stay stable. No drop, no duplicate.
- Latency: a vector accepted at edge E0 gives its first word valid after edge E1 (1 cycle). With out_ready held high, the N words appear on N consecutive cycles.
- Back-to-back vectors stream without a bubble when the next bank is FULL before the current last word is consumed.
- Bank freed and new vector captured in the same cycle:
  - in_ready updates from registered status, so a freed bank is visible one cycle later.
  - There is no combinational path from out_ready to in_ready.
  - A write and a read never target the same bank in the same cycle.
- Both banks FULL: in_ready=0 until the bank being read has had its last word loaded.
- Data passes unmodified: no rounding, scaling or sign change.

Test Plan:
- Reset, then one vector with lane k = {re=k, im=100+k}, REORDER=1, out_ready=1 -> 8 words, one per cycle, starting 1 cycle after accept. re = 0,4,2,6,1,5,3,7; im = 100,104,...,107 correspondingly; out_index = 0..7; out_last only on the 8th; in_ready stays 1.
- Same vector, out_ready pattern 1,0,0,1,0,1,... -> every stalled cycle holds data_out/out_index stable. Exactly 8 words accepted, in order, none repeated.
- Three vectors A, B, C offered back-to-back (re = 0x10+k, 0x20+k, 0x30+k), out_ready=1 -> A and B accepted on consecutive edges. C waits with in_ready=0 until A's last word loads. Output is 24 words with no gap after the first, and out_last on words 8, 16, 24.
- out_ready=0 held, offer 3 vectors -> the first two are accepted, in_ready=0, the third is not captured. Raising out_ready yields 16 words (both vectors, in order), then in_ready returns to 1.
- Assert rst_n=1 asynchronously after 3 words of a vector -> out_valid/data_out/out_index/out_last go to 0 without a clock edge. After release, in_ready=1 and the next vector starts at out_index 0 with no stale words.
- REORDER=0 with the first vector -> re = 0,1,2,...,7 in lane order.

Source files
------------

// File: rtl/fft_out_serializer_if.sv
// Handshake bundle for the FFT output serializer: parallel vector in, serial words out.
// The slave modport is the serializer's view; master is the producer/consumer side.
interface fft_out_serializer_if #(
   parameter int unsigned N    = 8,
   parameter int unsigned LOGN = 3,
   parameter int unsigned DW   = 34
) ();

   logic              in_valid;
   logic              in_ready;
   logic [N*DW-1:0]   data_in;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     data_out;
   logic [LOGN-1:0]   out_index;
   logic              out_last;

   modport slave (
      input  in_valid,
      input  data_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output data_out,
      output out_index,
      output out_last
   );

   modport master (
      output in_valid,
      output data_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  data_out,
      input  out_index,
      input  out_last
   );

endinterface

// File: rtl/fft_out_serializer.sv
// Ping-pong buffered serializer: captures an N-lane FFT result vector in one edge and
// emits it word by word, optionally undoing the butterfly's bit-reversed lane order.
module fft_out_serializer #(
   parameter int unsigned N       = 8,
   parameter int unsigned LOGN    = 3,
   parameter int unsigned DW      = 34,
   parameter bit          REORDER = 1'b1
) (
   input logic                 clk,
   input logic                 rst_n,
   fft_out_serializer_if.slave bus
);

   function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
      logic [LOGN-1:0] r;
      for (int unsigned i = 0; i < LOGN; i++) begin
         r[i] = v[LOGN-1-i];
      end
      return r;
   endfunction

   logic [DW-1:0]   bank_q [2][N];
   logic [1:0]      full_q, full_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [LOGN-1:0] cnt_q, cnt_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   data_out_q, data_out_d;
   logic [LOGN-1:0] out_index_q, out_index_d;
   logic            out_last_q, out_last_d;

   logic            accept;
   logic            load;
   logic            last_word;
   logic [LOGN-1:0] lane;

   assign lane      = REORDER ? bitrev(cnt_q) : cnt_q;
   assign last_word = (cnt_q == LOGN'(N - 1));
   // The write bank is only ever EMPTY and the read bank only ever FULL, so the two
   // sides never touch the same bank in one cycle.
   assign accept    = bus.in_valid && in_ready_q;
   assign load      = full_q[rd_ptr_q] && (!out_valid_q || bus.out_ready);

   always_comb begin
      full_d      = full_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      data_out_d  = data_out_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;

      if (accept) begin
         full_d[wr_ptr_q] = 1'b1;
         wr_ptr_d         = ~wr_ptr_q;
      end

      if (load) begin
         data_out_d  = bank_q[rd_ptr_q][lane];
         out_index_d = cnt_q;
         out_last_d  = last_word;
         out_valid_d = 1'b1;
         cnt_d       = cnt_q + LOGN'(1);
         if (last_word) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            cnt_d            = '0;
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      // Registered from next-state status: no combinational path from out_ready.
      in_ready_d = ~full_d[wr_ptr_d];
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         full_q      <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         full_q      <= full_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         data_out_q  <= data_out_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
      end
   end

   // Bank storage carries no reset; FULL flags alone decide what is valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned k = 0; k < N; k++) begin
            bank_q[wr_ptr_q][k] <= bus.data_in[k*DW +: DW];
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.data_out  = data_out_q;
   assign bus.out_index = out_index_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench: one REORDER=1 and one REORDER=0 serializer share the same stimulus and
// are each compared against hand-built expected word queues.
module tb_fft_out_serializer;

   localparam int unsigned N    = 8;
   localparam int unsigned LOGN = 3;
   localparam int unsigned DW   = 34;

   typedef struct packed {
      logic [DW-1:0]   data;
      logic [LOGN-1:0] idx;
      logic            last;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fft_out_serializer_if #(.N(N), .LOGN(LOGN), .DW(DW)) b ();
   fft_out_serializer_if #(.N(N), .LOGN(LOGN), .DW(DW)) b0 ();

   assign b0.in_valid  = b.in_valid;
   assign b0.data_in   = b.data_in;
   assign b0.out_ready = b.out_ready;

   fft_out_serializer #(.N(N), .LOGN(LOGN), .DW(DW), .REORDER(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b.slave)
   );

   fft_out_serializer #(.N(N), .LOGN(LOGN), .DW(DW), .REORDER(1'b0)) dut_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b0.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int ready_mode = 0;
   bit want_ready_hi = 1'b0;
   bit acc_pending = 1'b0;
   exp_t exp_q[$];
   exp_t exp0_q[$];
   logic [N*DW-1:0] vec_q[$];
   int acc_cyc[$];
   int rx_cyc[$];
   int br[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
   int pat[6] = '{1, 0, 0, 1, 0, 1};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic offer(input int re_base, input int im_base, input bit captured);
      logic [N*DW-1:0] v;
      exp_t e;
      for (int k = 0; k < N; k++) begin
         v[k*DW +: DW] = {17'(re_base + k), 17'(im_base + k)};
      end
      vec_q.push_back(v);
      if (captured) begin
         for (int j = 0; j < N; j++) begin
            e.idx  = LOGN'(j);
            e.last = (j == N - 1);
            e.data = {17'(re_base + br[j]), 17'(im_base + br[j])};
            exp_q.push_back(e);
            e.data = {17'(re_base + j), 17'(im_base + j)};
            exp0_q.push_back(e);
         end
      end
   endtask

   task automatic clear_all();
      exp_q.delete();
      exp0_q.delete();
      vec_q.delete();
      acc_cyc.delete();
      rx_cyc.delete();
      acc_pending = 1'b0;
   endtask

   // One cycle: observe at negedge, then drive inputs for the next rising edge.
   task automatic tick();
      bit rdy;
      @(negedge clk);
      cyc++;
      if (acc_pending) vec_q.delete(0);
      case (ready_mode)
         0:       rdy = 1'b0;
         1:       rdy = 1'b1;
         default: rdy = (pat[cyc % 6] != 0);
      endcase
      if (want_ready_hi) check("in_ready_hi", 64'(b.in_ready), 64'(1));
      if (b.out_valid) begin
         if (exp_q.size() == 0) check("r1_extra_word", 64'(b.out_valid), 64'(0));
         else begin
            check("r1_data", 64'(b.data_out), 64'(exp_q[0].data));
            check("r1_index", 64'(b.out_index), 64'(exp_q[0].idx));
            check("r1_last", 64'(b.out_last), 64'(exp_q[0].last));
            if (rdy) begin
               exp_q.delete(0);
               rx_cyc.push_back(cyc);
            end
         end
      end
      if (b0.out_valid) begin
         if (exp0_q.size() == 0) check("r0_extra_word", 64'(b0.out_valid), 64'(0));
         else begin
            check("r0_data", 64'(b0.data_out), 64'(exp0_q[0].data));
            check("r0_index", 64'(b0.out_index), 64'(exp0_q[0].idx));
            check("r0_last", 64'(b0.out_last), 64'(exp0_q[0].last));
            if (rdy) exp0_q.delete(0);
         end
      end
      b.out_ready = rdy;
      b.in_valid  = (vec_q.size() != 0);
      if (vec_q.size() != 0) b.data_in = vec_q[0];
      acc_pending = b.in_valid && b.in_ready;
      if (acc_pending) acc_cyc.push_back(cyc);
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while ((exp_q.size() != 0 || exp0_q.size() != 0 || vec_q.size() != 0) && guard < 300) begin
         tick();
         guard++;
      end
      check({tag, "_drained"}, 64'(exp_q.size() + exp0_q.size() + vec_q.size()), 64'(0));
      repeat (3) tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(b.in_ready), 64'(1));
      check({tag, "_out_valid"}, 64'(b.out_valid), 64'(0));
      check({tag, "_data_out"}, 64'(b.data_out), 64'(0));
      check({tag, "_out_index"}, 64'(b.out_index), 64'(0));
      check({tag, "_out_last"}, 64'(b.out_last), 64'(0));
      check({tag, "_r0_out_valid"}, 64'(b0.out_valid), 64'(0));
   endtask

   initial begin
      int guard;
      b.in_valid  = 1'b0;
      b.data_in   = '0;
      b.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("reset");

      // Single vector, full throughput, natural-order output.
      clear_all();
      ready_mode    = 1;
      want_ready_hi = 1'b1;
      offer(0, 100, 1'b1);
      drain("t1");
      check("t1_words", 64'(rx_cyc.size()), 64'(N));
      for (int j = 0; j < rx_cyc.size(); j++) begin
         check("t1_latency", 64'(rx_cyc[j] - acc_cyc[0]), 64'(j + 2));
      end

      // Same vector under a stalling consumer.
      clear_all();
      ready_mode = 2;
      offer(0, 100, 1'b1);
      drain("t2");
      check("t2_words", 64'(rx_cyc.size()), 64'(N));
      want_ready_hi = 1'b0;

      // Three back-to-back vectors: third waits for the first bank to free.
      clear_all();
      ready_mode = 1;
      offer('h10, 100, 1'b1);
      offer('h20, 100, 1'b1);
      offer('h30, 100, 1'b1);
      drain("t3");
      check("t3_accepts", 64'(acc_cyc.size()), 64'(3));
      check("t3_b_after_a", 64'(acc_cyc[1] - acc_cyc[0]), 64'(1));
      check("t3_c_after_a", 64'(acc_cyc[2] - acc_cyc[0]), 64'(9));
      check("t3_words", 64'(rx_cyc.size()), 64'(3 * N));
      for (int j = 0; j < rx_cyc.size(); j++) begin
         check("t3_no_gap", 64'(rx_cyc[j] - acc_cyc[0]), 64'(j + 2));
      end

      // Consumer blocked: two banks fill, third vector refused and then withdrawn.
      clear_all();
      ready_mode = 0;
      offer('h60, 150, 1'b1);
      offer('h68, 160, 1'b1);
      offer('h70, 170, 1'b0);
      repeat (8) tick();
      check("t4_accepts", 64'(acc_cyc.size()), 64'(2));
      check("t4_in_ready_lo", 64'(b.in_ready), 64'(0));
      vec_q.delete();
      tick();
      ready_mode = 1;
      drain("t4");
      check("t4_words", 64'(rx_cyc.size()), 64'(2 * N));
      check("t4_in_ready_back", 64'(b.in_ready), 64'(1));

      // Asynchronous reset in the middle of a vector.
      clear_all();
      ready_mode = 1;
      offer('h40, 200, 1'b1);
      guard = 0;
      while (rx_cyc.size() < 3 && guard < 50) begin
         tick();
         guard++;
      end
      check("t5_pre_words", 64'(rx_cyc.size()), 64'(3));
      #2 rst_n = 1'b1;
      #1 check_idle_outputs("t5_async");
      clear_all();
      b.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("t5_in_ready_after", 64'(b.in_ready), 64'(1));
      offer('h50, 300, 1'b1);
      drain("t5");
      check("t5_words", 64'(rx_cyc.size()), 64'(N));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
